// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants: field widths, opcode/aluop encodings, rstatus index and exception codes.
package cpu_isa_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned OPC_W   = 5;
   localparam int unsigned ALUOP_W = 5;

   localparam logic [OPC_W-1:0]   OPC_ALU     = 5'b00000;
   localparam logic [ALUOP_W-1:0] ALUOP_MUL   = 5'b00110;
   localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 5'b00111;
   localparam logic [REG_W-1:0]   RSTATUS_IDX = 5'd30;

   localparam logic [XLEN-1:0] EXC_MUL = 32'd4;
   localparam logic [XLEN-1:0] EXC_DIV = 32'd5;

endpackage

// File: rtl/md_sequencer_pkg.sv
// Types and helpers local to the multdiv sequencer.
package md_sequencer_pkg;
   import cpu_isa_pkg::*;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_e;

   typedef enum logic {
      KIND_MUL = 1'b0,
      KIND_DIV = 1'b1
   } md_kind_e;

   // Writeback request payload toward the register file.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } md_wb_t;

   // An execute-stage instruction that needs the multdiv unit.
   function automatic logic is_md_op(input logic               valid,
                                     input logic [OPC_W-1:0]   opcode,
                                     input logic [ALUOP_W-1:0] aluop);
      return valid && (opcode == OPC_ALU) &&
             ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
   endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Cycle counter for the BUSY wait: clear has priority over enable.
module md_cycle_counter #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   // Count register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/md_sequencer.sv
// Sequences mul/div instructions through the multicycle multdiv unit:
// stalls the front of the pipe, pulses the start, waits with timeout, then writes back.
module md_sequencer
   import cpu_isa_pkg::*, md_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT = 40
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               valid_x,
   input  logic [OPC_W-1:0]   opcode_x,
   input  logic [ALUOP_W-1:0] aluop_x,
   input  logic [REG_W-1:0]   rd_x,
   input  logic [XLEN-1:0]    op_a,
   input  logic [XLEN-1:0]    op_b,
   input  logic               flush,
   input  logic [XLEN-1:0]    md_result,
   input  logic               md_exception,
   input  logic               md_ready,
   output logic               ctrl_MULT,
   output logic               ctrl_DIV,
   output logic [XLEN-1:0]    md_a,
   output logic [XLEN-1:0]    md_b,
   output logic               stall,
   output logic               busy,
   output logic               wb_valid,
   output logic [REG_W-1:0]   wb_rd,
   output logic [XLEN-1:0]    wb_data
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   md_state_e        state_q, state_d;
   md_kind_e         kind_q, kind_d;
   logic [XLEN-1:0]  md_a_q, md_a_d;
   logic [XLEN-1:0]  md_b_q, md_b_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [REG_W-1:0] rd_q, rd_d;
   logic             exc_q, exc_d;
   logic             cnt_clear, cnt_enable;
   logic [CNT_W-1:0] cnt;
   logic             md_op;
   logic             timeout;
   md_wb_t           wb_c;

   assign md_op   = is_md_op(valid_x, opcode_x, aluop_x);
   assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

   md_cycle_counter #(
      .WIDTH (CNT_W)
   ) u_cycle_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (cnt)
   );

   // State and latched-operand registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         kind_q   <= KIND_MUL;
         md_a_q   <= '0;
         md_b_q   <= '0;
         result_q <= '0;
         rd_q     <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         md_a_q   <= md_a_d;
         md_b_q   <= md_b_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         exc_q    <= exc_d;
      end
   end

   // Next state, datapath capture and control outputs.
   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      md_a_d     = md_a_q;
      md_b_d     = md_b_q;
      result_d   = result_q;
      rd_d       = rd_q;
      exc_d      = exc_q;
      cnt_clear  = 1'b0;
      cnt_enable = 1'b0;
      ctrl_MULT  = 1'b0;
      ctrl_DIV   = 1'b0;
      stall      = 1'b0;
      wb_c       = '0;

      case (state_q)
         ST_IDLE: begin
            if (md_op && !flush) begin
               stall    = 1'b1;
               state_d  = ST_START;
               kind_d   = (aluop_x == ALUOP_DIV) ? KIND_DIV : KIND_MUL;
               md_a_d   = op_a;
               md_b_d   = op_b;
               rd_d     = rd_x;
               result_d = '0;
               exc_d    = 1'b0;
            end
         end
         ST_START: begin
            // md_ready is deliberately not looked at until the unit has been started.
            ctrl_MULT = (kind_q == KIND_MUL);
            ctrl_DIV  = (kind_q == KIND_DIV);
            cnt_clear = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               stall   = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_enable = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               stall = 1'b1;
               if (md_ready) begin
                  result_d = md_result;
                  exc_d    = md_exception;
                  state_d  = ST_DONE;
               end else if (timeout) begin
                  exc_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Always return to IDLE; the instruction still in execute is retiring, not new.
            state_d = ST_IDLE;
            if (!flush && (exc_q || (rd_q != '0))) begin
               wb_c.valid = 1'b1;
               wb_c.rd    = exc_q ? RSTATUS_IDX : rd_q;
               wb_c.data  = exc_q ? ((kind_q == KIND_DIV) ? EXC_DIV : EXC_MUL) : result_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign md_a     = md_a_q;
   assign md_b     = md_b_q;
   assign wb_valid = wb_c.valid;
   assign wb_rd    = wb_c.rd;
   assign wb_data  = wb_c.data;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a writeback scoreboard.
module tb_md_sequencer;

   localparam int unsigned TIMEOUT = 40;
   localparam logic [4:0]  OP_ADD  = 5'b00000;
   localparam logic [4:0]  OP_MUL  = 5'b00110;
   localparam logic [4:0]  OP_DIV  = 5'b00111;

   logic        clock = 1'b0;
   logic        reset;
   logic        valid_x;
   logic [4:0]  opcode_x;
   logic [4:0]  aluop_x;
   logic [4:0]  rd_x;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_ready;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        stall;
   logic        busy;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;
   int mult_pulses = 0;
   int div_pulses = 0;
   int exp_mult = 0;
   int exp_div = 0;
   logic [36:0] sb_q[$];
   logic [36:0] sb_e;

   md_sequencer #(
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .valid_x      (valid_x),
      .opcode_x     (opcode_x),
      .aluop_x      (aluop_x),
      .rd_x         (rd_x),
      .op_a         (op_a),
      .op_b         (op_b),
      .flush        (flush),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_ready     (md_ready),
      .ctrl_MULT    (ctrl_MULT),
      .ctrl_DIV     (ctrl_DIV),
      .md_a         (md_a),
      .md_b         (md_b),
      .stall        (stall),
      .busy         (busy),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data)
   );

   always #5 clock = ~clock;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic issue(input logic [4:0] aluop, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
      valid_x  = 1'b1;
      opcode_x = 5'b00000;
      aluop_x  = aluop;
      rd_x     = rd;
      op_a     = a;
      op_b     = b;
   endtask

   task automatic clear_x();
      valid_x  = 1'b0;
      opcode_x = 5'b00000;
      aluop_x  = 5'b00000;
      rd_x     = 5'd0;
      op_a     = 32'd0;
      op_b     = 32'd0;
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_stall"}, stall, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_mult"}, ctrl_MULT, 1'b0);
      chk1({tag, "_div"}, ctrl_DIV, 1'b0);
      chk1({tag, "_wbv"}, wb_valid, 1'b0);
      chk32({tag, "_md_a"}, md_a, 32'd0);
      chk32({tag, "_md_b"}, md_b, 32'd0);
   endtask

   // From the detection cycle: START (pulse checked), n quiet BUSY cycles, optional ready; ends in DONE.
   task automatic run_to_done(input bit is_mul, input int n, input bit give_ready,
                              input logic [31:0] res, input logic exc);
      cyc();
      smp();
      chk1("start_mult", ctrl_MULT, is_mul);
      chk1("start_div", ctrl_DIV, !is_mul);
      chk1("start_busy", busy, 1'b1);
      cyc();
      for (int i = 0; i < n; i++) begin
         smp();
         chk1("busy_stall", stall, 1'b1);
         chk1("busy_wbv", wb_valid, 1'b0);
         cyc();
      end
      if (give_ready) begin
         md_ready     = 1'b1;
         md_result    = res;
         md_exception = exc;
         smp();
         cyc();
         md_ready     = 1'b0;
         md_exception = 1'b0;
         md_result    = 32'hdead_beef;
      end
   endtask

   // Pulse counting and writeback scoreboard.
   always @(negedge clock) begin
      if (ctrl_MULT === 1'b1) mult_pulses++;
      if (ctrl_DIV === 1'b1) div_pulses++;
      if (wb_valid === 1'b1) begin
         chk1("wb_pending", sb_q.size() != 0, 1'b1);
         if (sb_q.size() != 0) begin
            sb_e = sb_q.pop_front();
            chk32("sb_wb_rd", 32'(wb_rd), 32'(sb_e[36:32]));
            chk32("sb_wb_data", wb_data, sb_e[31:0]);
         end
      end else begin
         chk32("idle_wb_rd", 32'(wb_rd), 32'd0);
         chk32("idle_wb_data", wb_data, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      flush        = 1'b0;
      md_ready     = 1'b0;
      md_exception = 1'b0;
      md_result    = 32'd0;
      clear_x();
      cyc();
      cyc();
      smp();
      check_all_zero("reset");
      cyc();
      reset = 1'b1;
      smp();
      check_all_zero("post_reset");
      cyc();

      // Non-md instruction: no stall, no pulse.
      issue(OP_ADD, 5'd4, 32'd1, 32'd2);
      for (int i = 0; i < 3; i++) begin
         smp();
         chk1("add_stall", stall, 1'b0);
         chk1("add_busy", busy, 1'b0);
         chk1("add_mult", ctrl_MULT, 1'b0);
         cyc();
      end

      // mul 6*7 rd=5, ready 17 cycles after the start pulse.
      issue(OP_MUL, 5'd5, 32'd6, 32'd7);
      sb_q.push_back({5'd5, 32'd42});
      exp_mult++;
      smp();
      chk1("det_stall", stall, 1'b1);
      chk1("det_busy", busy, 1'b0);
      chk1("det_mult", ctrl_MULT, 1'b0);
      cyc();
      smp();
      chk1("mul_start_mult", ctrl_MULT, 1'b1);
      chk1("mul_start_div", ctrl_DIV, 1'b0);
      chk1("mul_start_stall", stall, 1'b1);
      chk32("mul_md_a", md_a, 32'd6);
      chk32("mul_md_b", md_b, 32'd7);
      cyc();
      for (int i = 0; i < 16; i++) begin
         smp();
         chk1("mul_busy_stall", stall, 1'b1);
         chk1("mul_busy_mult", ctrl_MULT, 1'b0);
         cyc();
      end
      md_ready  = 1'b1;
      md_result = 32'd42;
      smp();
      chk1("mul_rdy_stall", stall, 1'b1);
      cyc();
      md_ready  = 1'b0;
      md_result = 32'hdead_beef;
      smp();
      chk1("mul_done_wbv", wb_valid, 1'b1);
      chk32("mul_done_rd", 32'(wb_rd), 32'd5);
      chk32("mul_done_data", wb_data, 32'd42);
      chk1("mul_done_stall", stall, 1'b0);
      chk1("mul_done_busy", busy, 1'b1);
      cyc();
      clear_x();
      smp();
      chk1("mul_idle_busy", busy, 1'b0);
      chk1("mul_idle_stall", stall, 1'b0);
      cyc();

      // div 9/0 with exception; md_ready asserted during START must be ignored.
      issue(OP_DIV, 5'd3, 32'd9, 32'd0);
      sb_q.push_back({5'd30, 32'd5});
      exp_div++;
      smp();
      cyc();
      md_ready     = 1'b1;
      md_exception = 1'b1;
      md_result    = 32'd77;
      smp();
      chk1("div_start_div", ctrl_DIV, 1'b1);
      chk1("div_start_mult", ctrl_MULT, 1'b0);
      cyc();
      smp();
      chk1("div_busy_busy", busy, 1'b1);
      chk1("div_busy_stall", stall, 1'b1);
      chk1("div_busy_wbv", wb_valid, 1'b0);
      cyc();
      md_ready     = 1'b0;
      md_exception = 1'b0;
      smp();
      chk1("div_done_wbv", wb_valid, 1'b1);
      chk32("div_done_rd", 32'(wb_rd), 32'd30);
      chk32("div_done_data", wb_data, 32'd5);
      cyc();
      clear_x();
      cyc();

      // mul timeout: TIMEOUT BUSY cycles without ready.
      issue(OP_MUL, 5'd7, 32'd3, 32'd3);
      sb_q.push_back({5'd30, 32'd4});
      exp_mult++;
      run_to_done(1'b1, TIMEOUT, 1'b0, 32'd0, 1'b0);
      smp();
      chk1("to_done_wbv", wb_valid, 1'b1);
      chk32("to_done_rd", 32'(wb_rd), 32'd30);
      chk32("to_done_data", wb_data, 32'd4);
      cyc();
      clear_x();
      smp();
      chk1("to_idle_busy", busy, 1'b0);
      cyc();

      // Ready on the final timeout cycle wins over the timeout.
      issue(OP_MUL, 5'd8, 32'd5, 32'd5);
      sb_q.push_back({5'd8, 32'd99});
      exp_mult++;
      run_to_done(1'b1, TIMEOUT - 1, 1'b1, 32'd99, 1'b0);
      smp();
      chk1("co_done_wbv", wb_valid, 1'b1);
      chk32("co_done_rd", 32'(wb_rd), 32'd8);
      chk32("co_done_data", wb_data, 32'd99);
      cyc();
      clear_x();
      cyc();

      // rd=0 without exception: no writeback.
      issue(OP_MUL, 5'd0, 32'd1, 32'd1);
      exp_mult++;
      run_to_done(1'b1, 0, 1'b1, 32'd55, 1'b0);
      smp();
      chk1("rd0_done_busy", busy, 1'b1);
      chk1("rd0_done_wbv", wb_valid, 1'b0);
      cyc();
      clear_x();
      cyc();

      // Flush in the third BUSY cycle.
      issue(OP_MUL, 5'd9, 32'd2, 32'd2);
      exp_mult++;
      smp();
      cyc();
      cyc();
      cyc();
      cyc();
      flush = 1'b1;
      smp();
      chk1("fl_busy3_busy", busy, 1'b1);
      chk1("fl_busy3_stall", stall, 1'b0);
      cyc();
      flush = 1'b0;
      clear_x();
      for (int i = 0; i < 4; i++) begin
         smp();
         chk1("fl_idle_busy", busy, 1'b0);
         chk1("fl_idle_stall", stall, 1'b0);
         chk1("fl_idle_wbv", wb_valid, 1'b0);
         cyc();
      end

      // Reset in the middle of BUSY.
      issue(OP_MUL, 5'd10, 32'd11, 32'd13);
      exp_mult++;
      smp();
      cyc();
      cyc();
      smp();
      chk32("rst_pre_md_a", md_a, 32'd11);
      chk1("rst_pre_busy", busy, 1'b1);
      cyc();
      reset = 1'b0;
      clear_x();
      smp();
      cyc();
      smp();
      check_all_zero("rst_busy");
      reset = 1'b1;
      cyc();
      smp();
      check_all_zero("rst_release");
      cyc();

      // Back-to-back muls: second detected in the cycle right after DONE.
      issue(OP_MUL, 5'd12, 32'd2, 32'd3);
      sb_q.push_back({5'd12, 32'd6});
      exp_mult++;
      run_to_done(1'b1, 2, 1'b1, 32'd6, 1'b0);
      smp();
      chk1("b2b_done1_wbv", wb_valid, 1'b1);
      chk1("b2b_done1_stall", stall, 1'b0);
      cyc();
      issue(OP_MUL, 5'd13, 32'd4, 32'd5);
      sb_q.push_back({5'd13, 32'd20});
      exp_mult++;
      smp();
      chk1("b2b_det2_stall", stall, 1'b1);
      chk1("b2b_det2_busy", busy, 1'b0);
      run_to_done(1'b1, 1, 1'b1, 32'd20, 1'b0);
      smp();
      chk32("b2b_done2_data", wb_data, 32'd20);
      chk32("b2b_md_a", md_a, 32'd4);
      cyc();
      clear_x();
      for (int i = 0; i < 3; i++) begin
         smp();
         chk1("b2b_tail_busy", busy, 1'b0);
         chk1("b2b_tail_mult", ctrl_MULT, 1'b0);
         cyc();
      end

      smp();
      chk32("mult_pulses", 32'(mult_pulses), 32'(exp_mult));
      chk32("div_pulses", 32'(div_pulses), 32'(exp_div));
      chk32("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40, meaning the maximum number of BUSY cycles to wait for the multdiv unit before forcing an exception.
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-low reset (0 = reset, sampled on the clock edge).
REQ-004 The block SHALL have port valid_x, input, 1, meaning the execute-stage instruction is valid.
REQ-005 The block SHALL have port opcode_x, input, 5, the execute-stage opcode.
REQ-006 The block SHALL have port aluop_x, input, 5, the execute-stage ALU op field.
REQ-007 The block SHALL have port rd_x, input, 5, the execute-stage destination register.
REQ-008 The block SHALL have ports op_a and op_b, input, 32 each, the execute-stage operands.
REQ-009 The block SHALL have port flush, input, 1, meaning cancel the instruction in execute.
REQ-010 The block SHALL have ports md_result (input, 32), md_exception (input, 1) and md_ready (input, 1), the multdiv unit outputs.
REQ-011 The block SHALL have ports ctrl_MULT and ctrl_DIV, output, 1 each, one-cycle start pulses to the multdiv unit.
REQ-012 The block SHALL have ports md_a and md_b, output, 32 each, the latched operands to the multdiv unit.
REQ-013 The block SHALL have port stall, output, 1, which freezes fetch, decode and execute.
REQ-014 The block SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-015 The block SHALL have ports wb_valid (output, 1), wb_rd (output, 5) and wb_data (output, 32), the writeback request.

Function
REQ-016 An instruction SHALL be an md-op when valid_x=1, opcode_x=00000 and aluop_x is 00110 (mul) or 00111 (div).
REQ-017 The FSM SHALL have the states IDLE, START, BUSY and DONE.
REQ-018 In IDLE, an md-op with flush=0 SHALL latch op_a/op_b into md_a/md_b, latch rd_x and the kind (mul or div), and move to START; otherwise the FSM SHALL stay in IDLE.
REQ-019 In START, exactly one of ctrl_MULT or ctrl_DIV SHALL be 1, per the latched kind, the cycle counter SHALL clear to 0, and the next state SHALL be BUSY; md_ready SHALL be ignored in START.
REQ-020 In BUSY, the counter SHALL increment each cycle; if md_ready=1, the FSM SHALL capture md_result and md_exception and go to DONE.
REQ-021 In BUSY, if the counter equals TIMEOUT-1 and md_ready=0, the FSM SHALL go to DONE with exception forced to 1.
REQ-022 If md_ready and the timeout coincide, md_ready SHALL take priority.
REQ-023 In DONE, the FSM SHALL go to IDLE unconditionally and SHALL NOT re-detect the instruction still held in execute.
REQ-024 stall SHALL equal (IDLE and md-op and not flush) or START or BUSY; stall SHALL be 0 in DONE.
REQ-025 In DONE, wb_valid SHALL be 1 for exactly one cycle, unless flush=1, or unless there is no exception and the latched rd is 0.
REQ-026 On exception, wb_rd SHALL be 30 and wb_data SHALL be 4 for mul or 5 for div; otherwise wb_rd SHALL be the latched rd and wb_data SHALL be the captured md_result.
REQ-027 flush=1 in START or BUSY SHALL abort to IDLE on the next edge, with no writeback; stall SHALL be 0 in that cycle.
REQ-028 wb_rd and wb_data SHALL be 0 whenever wb_valid=0.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE and clear the counter, md_a, md_b, the latched rd, kind and result, and all outputs to 0 from the next cycle, including during START, BUSY or DONE.

Structure
REQ-030 Opcode 00000, aluop codes 00110 and 00111, rstatus index 30 and exception codes 4 and 5 SHALL come from the shared ISA constants package cpu_isa_pkg.
REQ-031 The BUSY counter SHALL be one sub-module, md_cycle_counter, with ports clear, enable and count, and a width of ceil(log2(TIMEOUT+1)).

Verification
REQ-032 mul 6*7, rd=5, md_ready 17 cycles after ctrl_MULT: ctrl_MULT is a single pulse one cycle after detection, stall is high from detection through BUSY, then one wb_valid cycle with rd=5 and data=42.
REQ-033 div 9/0, rd=3, with md_exception=1 and md_ready=1: wb_rd=30 and wb_data=5.
REQ-034 mul with md_ready held at 0: after TIMEOUT BUSY cycles, wb_rd=30 and wb_data=4, then IDLE.
REQ-035 flush in BUSY cycle 3: IDLE next cycle, no wb_valid, stall=0; reset=0 mid-BUSY: all outputs 0 next cycle.
REQ-036 add (aluop 00000): no stall and no ctrl pulse.
REQ-037 Two consecutive muls: the second starts exactly one cycle after DONE, with no spurious restart on the first.
